// File: rtl/cfg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : cfg_uart_tx
// Description : 8N1 UART transmitter, LSB first, fed by a small input FIFO.
//               Queued bytes are sent back-to-back with no idle bit between
//               frames, so a configuration bitstream can be streamed out
//               continuously on the fabric's serial Rx input.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        Tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              LW         = AW + 1;
    localparam logic [LW-1:0]   C_DEPTH    = LW'(FIFO_DEPTH);
    localparam logic [15:0]     C_BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            bit_end;

    // Handshake and frame-boundary qualifiers.
    assign bit_end  = (baud_q == C_BIT_LAST);
    assign push     = tx_valid && tx_ready;
    // A byte leaves the FIFO only when the line is free: in IDLE, or on the
    // very last cycle of a stop bit so the next start bit follows directly.
    assign pop      = (level_q != '0) &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    assign tx_ready   = (level_q != C_DEPTH);
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level = level_q;
    assign Tx         = tx_q;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointer and occupancy update; power-of-two depth wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer; tx_d is the line value for the cycle after this edge,
    // so the serial output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                tx_d   = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State register; reset drops any frame in flight and empties the FIFO.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule
`default_nettype wire
